// File: rtl/reg_timeout_pkg.sv
// Shared types for the register-bus timeout cut: FSM state encoding and the
// default register-bus request/response structs.
package reg_timeout_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      RESP = 2'd2
   } reg_to_state_e;

   // Default regbus layout for 32-bit address and 32-bit data.
   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_bus_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_bus_rsp_t;

endpackage

// File: rtl/reg_timeout_cut.sv
// Register-bus pipeline cut with a transaction watchdog. One request is held
// in flight at a time. A peripheral that does not answer within
// TimeoutCycles is abandoned and the requester receives ErrRdata with error
// set. Every output comes straight from a register or from a state decode.
module reg_timeout_cut
   import reg_timeout_pkg::*;
#(
   parameter int unsigned          AddrWidth     = 32,
   parameter int unsigned          DataWidth     = 32,
   parameter int unsigned          IdWidth       = 4,
   parameter int unsigned          TimeoutCycles = 256,
   parameter logic [DataWidth-1:0] ErrRdata      = DataWidth'(32'hBADCAB1E),
   parameter int unsigned          CntWidth      = 8,
   parameter type                  reg_req_t     = reg_bus_req_t,
   parameter type                  reg_rsp_t     = reg_bus_rsp_t
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  reg_req_t             reg_req_i,
   output reg_rsp_t             reg_rsp_o,
   input  logic [IdWidth-1:0]   id_i,
   output reg_req_t             reg_req_o,
   input  reg_rsp_t             reg_rsp_i,
   output logic [IdWidth-1:0]   id_o,
   output logic                 busy_o,
   output logic                 timeout_o,
   output logic [AddrWidth-1:0] timeout_addr_o,
   output logic [IdWidth-1:0]   timeout_id_o,
   output logic [CntWidth-1:0]  timeout_cnt_o
);

   // The wait counter only has to reach TimeoutCycles-1, so it never wraps.
   localparam int unsigned WaitWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
   localparam logic [WaitWidth-1:0] WaitLast =
      WaitWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
   localparam bit WatchdogOn = (TimeoutCycles != 0);

   reg_to_state_e state_q, state_d;

   logic [AddrWidth-1:0]   addr_q;
   logic                   write_q;
   logic [DataWidth-1:0]   wdata_q;
   logic [DataWidth/8-1:0] wstrb_q;
   logic [IdWidth-1:0]     id_q;
   logic [WaitWidth-1:0]   wait_cnt_q;
   logic [DataWidth-1:0]   rdata_q;
   logic                   error_q;
   logic                   timeout_q;
   logic [AddrWidth-1:0]   to_addr_q;
   logic [IdWidth-1:0]     to_id_q;
   logic [CntWidth-1:0]    to_cnt_q;

   logic timeout_hit;

   // Watchdog fires on the last allowed FWD cycle unless ready arrives in it.
   assign timeout_hit = WatchdogOn && (state_q == FWD) && !reg_rsp_i.ready &&
                        (wait_cnt_q == WaitLast);

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic.
   // NOTE: state_d gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (reg_req_i.valid) state_d = FWD;
         FWD:     if (reg_rsp_i.ready || timeout_hit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Captured request, wait counter, captured response and timeout status.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q     <= '0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         id_q       <= '0;
         wait_cnt_q <= '0;
         rdata_q    <= '0;
         error_q    <= 1'b0;
         timeout_q  <= 1'b0;
         to_addr_q  <= '0;
         to_id_q    <= '0;
         to_cnt_q   <= '0;
      end else begin
         timeout_q <= timeout_hit;
         unique case (state_q)
            IDLE: begin
               if (reg_req_i.valid) begin
                  addr_q     <= reg_req_i.addr;
                  write_q    <= reg_req_i.write;
                  wdata_q    <= reg_req_i.wdata;
                  wstrb_q    <= reg_req_i.wstrb;
                  id_q       <= id_i;
                  wait_cnt_q <= '0;
               end
            end
            FWD: begin
               if (WatchdogOn) wait_cnt_q <= wait_cnt_q + WaitWidth'(1);
               if (reg_rsp_i.ready) begin
                  rdata_q <= reg_rsp_i.rdata;
                  error_q <= reg_rsp_i.error;
               end else if (timeout_hit) begin
                  rdata_q   <= ErrRdata;
                  error_q   <= 1'b1;
                  to_addr_q <= addr_q;
                  to_id_q   <= id_q;
                  if (!(&to_cnt_q)) to_cnt_q <= to_cnt_q + CntWidth'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Bus outputs: request fields only in FWD, response only in RESP.
   always_comb begin
      reg_req_o = '0;
      reg_rsp_o = '0;
      if (state_q == FWD) begin
         reg_req_o.addr  = addr_q;
         reg_req_o.write = write_q;
         reg_req_o.wdata = wdata_q;
         reg_req_o.wstrb = wstrb_q;
         reg_req_o.valid = 1'b1;
      end
      if (state_q == RESP) begin
         reg_rsp_o.rdata = rdata_q;
         reg_rsp_o.error = error_q;
         reg_rsp_o.ready = 1'b1;
      end
   end

   assign id_o           = id_q;
   assign busy_o         = (state_q != IDLE);
   assign timeout_o      = timeout_q;
   assign timeout_addr_o = to_addr_q;
   assign timeout_id_o   = to_id_q;
   assign timeout_cnt_o  = to_cnt_q;

endmodule

// File: tb/tb_reg_timeout_cut.sv
// Directed bench for reg_timeout_cut with a response scoreboard.
module tb_reg_timeout_cut;
   import reg_timeout_pkg::*;

   localparam int unsigned TO  = 8;
   localparam int unsigned CW  = 2;
   localparam int unsigned IDW = 4;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b1;
   reg_bus_req_t reg_req_i, reg_req_o;
   reg_bus_rsp_t reg_rsp_i, reg_rsp_o;
   logic [IDW-1:0] id_i, id_o, timeout_id_o;
   logic           busy_o, timeout_o;
   logic [31:0]    timeout_addr_o;
   logic [CW-1:0]  timeout_cnt_o;

   always #5 clk_i = ~clk_i;

   reg_timeout_cut #(
      .AddrWidth     (32),
      .DataWidth     (32),
      .IdWidth       (IDW),
      .TimeoutCycles (TO),
      .ErrRdata      (32'hBADCAB1E),
      .CntWidth      (CW),
      .reg_req_t     (reg_bus_req_t),
      .reg_rsp_t     (reg_bus_rsp_t)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .reg_req_i      (reg_req_i),
      .reg_rsp_o      (reg_rsp_o),
      .id_i           (id_i),
      .reg_req_o      (reg_req_o),
      .reg_rsp_i      (reg_rsp_i),
      .id_o           (id_o),
      .busy_o         (busy_o),
      .timeout_o      (timeout_o),
      .timeout_addr_o (timeout_addr_o),
      .timeout_id_o   (timeout_id_o),
      .timeout_cnt_o  (timeout_cnt_o)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        error;
      logic        to;
      int          lat;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model of the status registers.
   int          exp_cnt     = 0;
   logic [31:0] exp_to_addr = '0;
   logic [3:0]  exp_to_id   = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_status();
      check("timeout_cnt", 64'(timeout_cnt_o), 64'(exp_cnt));
      check("timeout_addr", 64'(timeout_addr_o), 64'(exp_to_addr));
      check("timeout_id", 64'(timeout_id_o), 64'(exp_to_id));
   endtask

   // One transaction, driven at a negedge. k = FWD cycle in which downstream
   // answers (0 = never). Ends at the negedge of the idle cycle after RESP.
   task automatic txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input logic [3:0] id, input int k,
                      input logic [31:0] drdata);
      exp_t e, g;
      bit   got;
      bit   is_to;
      int   vcnt;
      is_to   = !(k >= 1 && k <= int'(TO));
      e.rdata = is_to ? 32'hBADCAB1E : drdata;
      e.error = is_to;
      e.to    = is_to;
      e.lat   = is_to ? int'(TO) + 1 : k + 1;
      sb.push_back(e);
      if (is_to) begin
         exp_cnt     = (exp_cnt == 3) ? 3 : exp_cnt + 1;
         exp_to_addr = addr;
         exp_to_id   = id;
      end
      reg_req_i = '{addr: addr, write: wr, wdata: wdata, wstrb: wstrb, valid: 1'b1};
      id_i      = id;
      got  = 1'b0;
      vcnt = 0;
      for (int n = 1; n <= 40 && !got; n++) begin
         @(negedge clk_i);
         if (reg_req_o.valid) begin
            vcnt++;
            check("dn_addr", 64'(reg_req_o.addr), 64'(addr));
            check("dn_write", 64'(reg_req_o.write), 64'(wr));
            check("dn_wdata", 64'(reg_req_o.wdata), 64'(wdata));
            check("dn_wstrb", 64'(reg_req_o.wstrb), 64'(wstrb));
            check("id_o", 64'(id_o), 64'(id));
            check("busy_fwd", 64'(busy_o), 64'd1);
         end
         if (reg_rsp_o.ready) begin
            got = 1'b1;
            g   = sb.pop_front();
            check("rsp_rdata", 64'(reg_rsp_o.rdata), 64'(g.rdata));
            check("rsp_error", 64'(reg_rsp_o.error), 64'(g.error));
            check("timeout_pulse", 64'(timeout_o), 64'(g.to));
            check("latency", 64'(n), 64'(g.lat));
            check("valid_cycles", 64'(vcnt), 64'(g.lat - 1));
            reg_req_i = '0;
         end else begin
            check("no_pulse", 64'(timeout_o), 64'd0);
         end
         reg_rsp_i = '{rdata: drdata, error: 1'b0, ready: (n == k)};
      end
      reg_rsp_i = '0;
      check("resp_seen", 64'(got), 64'd1);
      if (!got) reg_req_i = '0;
      @(negedge clk_i);
      check("idle_busy", 64'(busy_o), 64'd0);
      check("idle_req", 64'(reg_req_o), 64'd0);
      check("idle_rsp", 64'(reg_rsp_o), 64'd0);
      check("idle_pulse", 64'(timeout_o), 64'd0);
      check_status();
   endtask

   initial begin
      reg_req_i = '0;
      reg_rsp_i = '0;
      id_i      = '0;
      #2 rst_ni = 1'b0;
      @(negedge clk_i);
      check("rst_req", 64'(reg_req_o), 64'd0);
      check("rst_rsp", 64'(reg_rsp_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_id", 64'(id_o), 64'd0);
      check("rst_pulse", 64'(timeout_o), 64'd0);
      check_status();
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Immediate read.
      txn(32'h0000000C, 1'b0, 32'h0, 4'h0, 4'd1, 1, 32'h00001234);
      // Stalled write, downstream answers after 5 cycles.
      txn(32'h00000010, 1'b1, 32'hA5A5A5A5, 4'hF, 4'd3, 5, 32'h0);
      // Timeout.
      txn(32'h00000020, 1'b0, 32'h0, 4'h0, 4'd5, 0, 32'h0);
      // Ready in the last allowed cycle wins over the watchdog.
      txn(32'h00000024, 1'b0, 32'h0, 4'h0, 4'd6, int'(TO), 32'hCAFE0008);

      // Reset during the third FWD cycle drops the transaction.
      reg_req_i = '{addr: 32'h30, write: 1'b1, wdata: 32'h11, wstrb: 4'h1, valid: 1'b1};
      id_i      = 4'd7;
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check("rstfwd_valid", 64'(reg_req_o.valid), 64'd0);
      check("rstfwd_req", 64'(reg_req_o), 64'd0);
      check("rstfwd_rsp", 64'(reg_rsp_o), 64'd0);
      check("rstfwd_busy", 64'(busy_o), 64'd0);
      check("rstfwd_id", 64'(id_o), 64'd0);
      check("rstfwd_pulse", 64'(timeout_o), 64'd0);
      exp_cnt     = 0;
      exp_to_addr = '0;
      exp_to_id   = '0;
      check_status();
      reg_req_i = '0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      txn(32'h00000040, 1'b0, 32'h0, 4'h0, 4'd2, 2, 32'h0BEEF000);

      // Five consecutive timeouts: counter saturates at 3.
      for (int i = 0; i < 5; i++)
         txn(32'h100 + 32'(i * 4), 1'b0, 32'h0, 4'h0, 4'(8 + i), 0, 32'h0);

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
